// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM access scheduler.
package vram_pkg;

  localparam int unsigned VRAM_AW = 19;

  localparam logic [1:0] BE_LO  = 2'b01;
  localparam logic [1:0] BE_HI  = 2'b10;
  localparam logic [1:0] BE_ALL = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StVid1,
    StVid2,
    StCpu,
    StLdr
  } sched_state_t;

endpackage

// File: rtl/vram_sched_if.sv
// Client and memory-port bundle for vram_sched; slave = scheduler view, master = environment view.
interface vram_sched_if
  import vram_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW
) ();

  logic          vid_fetch;
  logic [AW-1:0] vid_addr1;
  logic [AW-1:0] vid_addr2;
  logic [15:0]   vid_dout1;
  logic [15:0]   vid_dout2;
  logic          vid_valid;
  logic          vid_overrun;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW:0]   cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;

  logic          ldr_wr;
  logic [AW-1:0] ldr_addr;
  logic [15:0]   ldr_data;
  logic          ldr_busy;

  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout;
  logic          mem_ack;

  modport slave (
    input  vid_fetch, vid_addr1, vid_addr2,
    output vid_dout1, vid_dout2, vid_valid, vid_overrun,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack,
    input  ldr_wr, ldr_addr, ldr_data,
    output ldr_busy,
    output mem_req, mem_we, mem_be, mem_addr, mem_din,
    input  mem_dout, mem_ack
  );

  modport master (
    output vid_fetch, vid_addr1, vid_addr2,
    input  vid_dout1, vid_dout2, vid_valid, vid_overrun,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack,
    output ldr_wr, ldr_addr, ldr_data,
    input  ldr_busy,
    input  mem_req, mem_we, mem_be, mem_addr, mem_din,
    output mem_dout, mem_ack
  );

endinterface

// File: rtl/vram_sched.sv
// Fixed-priority (video > CPU > loader) scheduler for a single 16-bit VRAM port.
// Define VRAM_SCHED_LOADER_EN to build the loader write path.
module vram_sched
  import vram_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW
) (
  input  logic         clk_sys,
  input  logic         nRESET,
  vram_sched_if.slave  bus
);

  sched_state_t  state_q, state_d;

  logic          vid_pend_q, vid_pend_d;
  logic          vid_half_q, vid_half_d;
  logic          vid_restart_q, vid_restart_d;
  logic [AW-1:0] vid_a1_q, vid_a1_d;
  logic [AW-1:0] vid_a2_q, vid_a2_d;
  logic [15:0]   vid_w1_q, vid_w1_d;
  logic [15:0]   vid_dout1_q, vid_dout1_d;
  logic [15:0]   vid_dout2_q, vid_dout2_d;
  logic          vid_valid_q, vid_valid_d;
  logic          vid_overrun_q, vid_overrun_d;
  logic          vid_restart;

  logic          cpu_done_q, cpu_done_d;
  logic          cpu_lane_q, cpu_lane_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          cpu_ack_q, cpu_ack_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [1:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_din_q, mem_din_d;

`ifdef VRAM_SCHED_LOADER_EN
  logic          ldr_busy_q, ldr_busy_d;
  logic [AW-1:0] ldr_addr_q, ldr_addr_d;
  logic [15:0]   ldr_data_q, ldr_data_d;
`else
  logic          unused_ldr;
  assign unused_ldr = ^{bus.ldr_wr, bus.ldr_addr, bus.ldr_data};
`endif

  always_comb begin
    state_d       = state_q;
    vid_pend_d    = vid_pend_q;
    vid_half_d    = vid_half_q;
    vid_restart_d = vid_restart_q;
    vid_a1_d      = vid_a1_q;
    vid_a2_d      = vid_a2_q;
    vid_w1_d      = vid_w1_q;
    vid_dout1_d   = vid_dout1_q;
    vid_dout2_d   = vid_dout2_q;
    vid_valid_d   = 1'b0;
    vid_overrun_d = vid_overrun_q;
    cpu_done_d    = cpu_done_q;
    cpu_lane_d    = cpu_lane_q;
    cpu_dout_d    = cpu_dout_q;
    cpu_ack_d     = 1'b0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_be_d      = mem_be_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
`ifdef VRAM_SCHED_LOADER_EN
    ldr_busy_d    = ldr_busy_q;
    ldr_addr_d    = ldr_addr_q;
    ldr_data_d    = ldr_data_q;
    if (bus.ldr_wr && !ldr_busy_q) begin
      ldr_busy_d = 1'b1;
      ldr_addr_d = bus.ldr_addr;
      ldr_data_d = bus.ldr_data;
    end
`endif

    // A fetch while a pair is pending replaces it; any in-flight word is discarded.
    vid_restart = bus.vid_fetch & vid_pend_q;
    if (bus.vid_fetch) begin
      vid_pend_d = 1'b1;
      vid_a1_d   = bus.vid_addr1;
      vid_a2_d   = bus.vid_addr2;
    end
    if (vid_restart) begin
      vid_overrun_d = 1'b1;
      vid_restart_d = 1'b1;
      vid_half_d    = 1'b0;
    end

    if (!bus.cpu_req) cpu_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (vid_pend_q || bus.vid_fetch) begin
          if (vid_half_q && !bus.vid_fetch) begin
            state_d    = StVid2;
            mem_addr_d = vid_a2_q;
          end else begin
            state_d       = StVid1;
            mem_addr_d    = vid_a1_d;
            vid_restart_d = 1'b0;
            vid_half_d    = 1'b0;
          end
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          mem_be_d  = BE_ALL;
        end else if (bus.cpu_req && !cpu_done_q) begin
          state_d    = StCpu;
          mem_req_d  = 1'b1;
          mem_addr_d = bus.cpu_addr[AW:1];
          cpu_lane_d = bus.cpu_addr[0];
          if (bus.cpu_we) begin
            mem_we_d  = 1'b1;
            mem_be_d  = bus.cpu_addr[0] ? BE_HI : BE_LO;
            mem_din_d = {bus.cpu_din, bus.cpu_din};
          end else begin
            mem_we_d  = 1'b0;
            mem_be_d  = BE_ALL;
          end
        end
`ifdef VRAM_SCHED_LOADER_EN
        else if (ldr_busy_q) begin
          state_d    = StLdr;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_be_d   = BE_ALL;
          mem_addr_d = ldr_addr_q;
          mem_din_d  = ldr_data_q;
        end
`endif
      end
      StVid1: begin
        if (bus.mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          if (!vid_restart_q && !vid_restart) begin
            vid_w1_d   = bus.mem_dout;
            vid_half_d = 1'b1;
          end
        end
      end
      StVid2: begin
        if (bus.mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          if (!vid_restart_q && !vid_restart) begin
            vid_dout1_d = vid_w1_q;
            vid_dout2_d = bus.mem_dout;
            vid_valid_d = 1'b1;
            vid_pend_d  = 1'b0;
            vid_half_d  = 1'b0;
          end
        end
      end
      StCpu: begin
        if (bus.mem_ack) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          cpu_done_d = 1'b1;
          cpu_ack_d  = 1'b1;
          if (!mem_we_q) cpu_dout_d = cpu_lane_q ? bus.mem_dout[15:8] : bus.mem_dout[7:0];
        end
      end
`ifdef VRAM_SCHED_LOADER_EN
      StLdr: begin
        if (bus.mem_ack) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          ldr_busy_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state_q       <= StIdle;
      vid_pend_q    <= 1'b0;
      vid_half_q    <= 1'b0;
      vid_restart_q <= 1'b0;
      vid_a1_q      <= '0;
      vid_a2_q      <= '0;
      vid_w1_q      <= '0;
      vid_dout1_q   <= '0;
      vid_dout2_q   <= '0;
      vid_valid_q   <= 1'b0;
      vid_overrun_q <= 1'b0;
      cpu_done_q    <= 1'b0;
      cpu_lane_q    <= 1'b0;
      cpu_dout_q    <= '0;
      cpu_ack_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
    end else begin
      state_q       <= state_d;
      vid_pend_q    <= vid_pend_d;
      vid_half_q    <= vid_half_d;
      vid_restart_q <= vid_restart_d;
      vid_a1_q      <= vid_a1_d;
      vid_a2_q      <= vid_a2_d;
      vid_w1_q      <= vid_w1_d;
      vid_dout1_q   <= vid_dout1_d;
      vid_dout2_q   <= vid_dout2_d;
      vid_valid_q   <= vid_valid_d;
      vid_overrun_q <= vid_overrun_d;
      cpu_done_q    <= cpu_done_d;
      cpu_lane_q    <= cpu_lane_d;
      cpu_dout_q    <= cpu_dout_d;
      cpu_ack_q     <= cpu_ack_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_be_q      <= mem_be_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
    end
  end

`ifdef VRAM_SCHED_LOADER_EN
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      ldr_busy_q <= 1'b0;
      ldr_addr_q <= '0;
      ldr_data_q <= '0;
    end else begin
      ldr_busy_q <= ldr_busy_d;
      ldr_addr_q <= ldr_addr_d;
      ldr_data_q <= ldr_data_d;
    end
  end
  assign bus.ldr_busy = ldr_busy_q;
`else
  assign bus.ldr_busy = 1'b0;
`endif

  assign bus.vid_dout1   = vid_dout1_q;
  assign bus.vid_dout2   = vid_dout2_q;
  assign bus.vid_valid   = vid_valid_q;
  assign bus.vid_overrun = vid_overrun_q;
  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;

endmodule

// File: doc/vram_sched.md
# vram_sched

Single-port VRAM access scheduler sharing one 16-bit word-wide memory port between the video fetch engine, the Z80 CPU memory cycle and the ROM/disk-image loader. It sits between the video controller, the CPU bus decoder and the SRAM/SDRAM controller. Priority is fixed: video first, then CPU, then loader. At most one memory access is outstanding at any time.

## Interface
Parameters:
- AW, 19, memory word-address width.

Ports:
- clk_sys  in  1  master clock; all logic is on its rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- vid_fetch  in  1  one-cycle strobe requesting a video word pair.
- vid_addr1, vid_addr2  in  AW  word addresses; sampled on vid_fetch.
- vid_dout1, vid_dout2  out  16  fetched words; held until the next pair completes.
- vid_valid  out  1  one-cycle pulse when both words are captured.
- vid_overrun  out  1  sticky; set when vid_fetch arrives while a pair is still pending.
- cpu_req  in  1  level; held high for the whole CPU memory cycle.
- cpu_we  in  1  1 = write.
- cpu_addr  in  AW+1  byte address; bit 0 selects the lane (0 = [7:0]).
- cpu_din  in  8  write data.
- cpu_dout  out  8  read byte; held after the access.
- cpu_ack  out  1  one-cycle pulse on completion.
- ldr_wr  in  1  one-cycle write strobe.
- ldr_addr  in  AW  word address.
- ldr_data  in  16  write data.
- ldr_busy  out  1  high from acceptance until completion.
- mem_req  out  1  access request.
- mem_we  out  1  write enable.
- mem_be  out  2  byte enables.
- mem_addr  out  AW  word address.
- mem_din  out  16  write data.
- mem_dout  in  16  read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion; earliest one cycle after mem_req rises.

## Operation
- FSM states: IDLE, VID1, VID2, CPU, LDR.
- Arbitration happens in IDLE only. Priority order:
  - vid_pend → VID1
  - cpu_req & ~cpu_done → CPU
  - ldr_pend → LDR
- Active states:
  - mem_req is high and addr/we/be/din are stable until mem_ack.
  - On mem_ack:
    - VID1 → VID2
    - VID2 → IDLE, with vid_valid pulsed
    - CPU, LDR → IDLE
- Video:
  - VID1 reads vid_addr1 and VID2 reads vid_addr2.
  - mem_be = 11, mem_we = 0.
  - mem_dout is latched into vid_dout1/vid_dout2. The two outputs update together when VID2 is acked, never one without the other.
- vid_fetch while vid_pend is set:
  - The new addresses replace the latched ones and vid_overrun is set.
  - An access already in flight completes, then the FSM restarts at VID1 with the new addresses.
  - No vid_valid is produced for the replaced pair.
- CPU:
  - Word address is cpu_addr[AW:1].
  - Write: mem_din = {cpu_din, cpu_din}, mem_be = 01 or 10 by lane.
  - Read: mem_be = 11, and the lane byte is latched into cpu_dout.
  - cpu_done is set on ack and cleared when cpu_req is low, so one held request is serviced exactly once.
- Loader:
  - ldr_wr is accepted only when ldr_busy = 0. While busy it is ignored.
  - Write uses mem_be = 11.
- vid_fetch and cpu_req arriving in the same cycle: video wins.
- CPU may be delayed by at most one video pair plus one access in flight. The loader may starve; that is acceptable.

## Timing
- Every access takes at least 3 cycles: request cycle(s), ack cycle, then one IDLE cycle with mem_req = 0.
- vid_fetch at cycle t with the FSM idle and zero-wait memory:
  - mem_req at t+1, ack at t+2
  - IDLE at t+3, VID2 req at t+4, ack at t+5
  - vid_valid at t+6
- cpu_ack is asserted the cycle after mem_ack.
- Reset values:
  - state = IDLE
  - all pending/done flags = 0
  - mem_req = 0, mem_we = 0, mem_be = 00, mem_addr = 0, mem_din = 0
  - vid_dout1 = vid_dout2 = 0
  - vid_valid = 0, vid_overrun = 0
  - cpu_dout = 0, cpu_ack = 0
  - ldr_busy = 0
- Reset mid-access: abandoned immediately. The memory controller must tolerate mem_req dropping before mem_ack.

## Configuration
- VRAM_SCHED_LOADER_EN defined: loader port and LDR state present as described.
- Not defined:
  - ldr_* inputs are ignored and ldr_busy is tied to 0.
  - The LDR state and ldr_pend are not synthesised.

## Structure
- Shared package vram_pkg holds:
  - the sched_state_t enum
  - VRAM_AW = 19
  - the BE_LO/BE_HI/BE_ALL constants
- The single module has no sub-module: the FSM and its datapath registers are too tightly coupled to split usefully.

## Test plan
- vid_fetch with addrs 0x00100/0x00101, memory returning 0x1234/0xABCD with 0-wait → vid_valid at t+6, vid_dout1 = 0x1234, vid_dout2 = 0xABCD.
- CPU write, cpu_addr 0x00201, cpu_din 0x5A → mem_addr 0x00100, mem_be 10, mem_din 0x5A5A, single cpu_ack. cpu_req held 20 cycles → no second access.
- cpu_req and vid_fetch in the same cycle → both video words served first; cpu_ack follows VID2 by ≥3 cycles.
- Second vid_fetch during VID1 with a 4-cycle wait → vid_overrun = 1, exactly one vid_valid, carrying the second pair's data.
- ldr_wr twice 1 cycle apart → only the first accepted; ldr_busy high until its ack (with VRAM_SCHED_LOADER_EN undefined: no memory access, ldr_busy = 0).
- nRESET low while mem_req is high → mem_req = 0 the same cycle; after release, a CPU read completes normally.
